// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Ports: clk/reset; ID instruction info (id_*); ex_redirect, mem_busy in;
// stage enables/flushes, id_byp, fwd_sel and stall_cnt out.
module pipe_hazard_ctrl #(
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [NRP*AW-1:0]  id_rs,
    input  logic [NRP-1:0]     id_rs_used,
    input  logic [AW-1:0]      id_rd,
    input  logic               id_regwrite,
    input  logic               id_is_load,
    input  logic               ex_redirect,
    input  logic               mem_busy,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_en,
    output logic               idex_flush,
    output logic               exmem_en,
    output logic               memwb_en,
    output logic [NRP-1:0]     id_byp,
    output logic [NRP*2-1:0]   fwd_sel,
    output logic [CNT_W-1:0]   stall_cnt
);

    // The load flag only matters while the producer sits in EX.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
    } ex_slot_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wr;
    } slot_t;

    ex_slot_t          ex_q, ex_d;
    slot_t             mem_q, wb_q;
    logic [NRP*2-1:0]  fwd_q, fwd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NRP-1:0]    m_ex, m_mem, m_wb;
    logic              hz;
    logic              stall_take;

    function automatic logic match(
        input logic          v,
        input logic          wr,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] rs,
        input logic          used,
        input logic          iv
    );
        return v & wr & (rd == rs) & (rs != '0) & used & iv;
    endfunction

    always_comb begin
        m_ex  = '0;
        m_mem = '0;
        m_wb  = '0;
        for (int k = 0; k < NRP; k++) begin
            m_ex[k]  = match(ex_q.v, ex_q.wr, ex_q.rd,
                             id_rs[k*AW +: AW], id_rs_used[k], id_valid);
            m_mem[k] = match(mem_q.v, mem_q.wr, mem_q.rd,
                             id_rs[k*AW +: AW], id_rs_used[k], id_valid);
            m_wb[k]  = match(wb_q.v, wb_q.wr, wb_q.rd,
                             id_rs[k*AW +: AW], id_rs_used[k], id_valid);
        end
    end

    // Without forwarding, any producer still ahead of WB blocks the reader.
    always_comb begin
        hz = 1'b0;
        if (FWD_EN != 0) begin
            hz = |m_ex & ex_q.ld;
        end else begin
            hz = |(m_ex | m_mem);
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        stall_take = 1'b0;
        priority case (1'b1)
            reset: begin
            end
            mem_busy: begin
            end
            ex_redirect: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            hz: begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                stall_take = 1'b1;
            end
            default: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (!idex_flush && id_valid) begin
            ex_d.v  = 1'b1;
            ex_d.rd = id_rd;
            ex_d.wr = id_regwrite;
            ex_d.ld = id_is_load;
        end
    end

    // Youngest producer wins; a load in EX is covered by the stall.
    always_comb begin
        fwd_d = '0;
        if (!idex_flush && FWD_EN != 0) begin
            for (int k = 0; k < NRP; k++) begin
                if (m_ex[k] && !ex_q.ld) begin
                    fwd_d[2*k +: 2] = 2'b01;
                end else if (m_mem[k]) begin
                    fwd_d[2*k +: 2] = 2'b10;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_take && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (idex_en) begin
                ex_q  <= ex_d;
                fwd_q <= fwd_d;
            end
            if (exmem_en) begin
                mem_q.v  <= ex_q.v;
                mem_q.rd <= ex_q.rd;
                mem_q.wr <= ex_q.wr;
            end
            if (memwb_en) begin
                wb_q <= mem_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign id_byp    = m_wb;
    assign fwd_sel   = fwd_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage pipelined core (IF, ID, EX, MEM, WB).
- Keeps a scoreboard of destination registers for the instructions in ID/EX, EX/MEM and MEM/WB.
- From that scoreboard it drives the pipeline-register enables and flushes, load-use stalls, branch-redirect flushes, memory-busy freezes and per-operand forwarding selects.
- Generalises single-cycle control to N read ports, with a selectable forwarding or stall-only mode and a stall performance counter.

Parameters:
- AW, 5: register address width; register 0 is hardwired zero.
- NRP, 2: number of source-operand read ports.
- FWD_EN, 1: 1 = forward from MEM/WB stages; 0 = stall until the producer reaches WB.
- CNT_W, 32: width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NRP*AW  packed source register ids; port k = bits [k*AW +: AW]
- id_rs_used  in  NRP  port k is actually read by the instruction
- id_rd  in  AW  destination register id
- id_regwrite  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load (result available in MEM/WB only)
- ex_redirect  in  1  taken branch or jump resolved in EX (NPC not PC+4)
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  load bubble into IF/ID
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  load bubble into ID/EX
- exmem_en  out  1  EX/MEM register enable
- memwb_en  out  1  MEM/WB register enable
- id_byp  out  NRP  port k must take WB write data instead of the RF read (same-cycle write/read)
- fwd_sel  out  NRP*2  registered; applies to the instruction in EX. 00 = RF/ID value, 01 = EX/MEM ALU result, 10 = MEM/WB write data, 11 unused
- stall_cnt  out  CNT_W  cycles in which a load-use or FWD_EN=0 stall was asserted (saturating)

Behaviour:
- Scoreboard: three slots, S_EX, S_MEM and S_WB, each holding {v, rd, wr, ld}.
- Match(slot, k) = slot.v & slot.wr & slot.rd == id_rs[k] & id_rs[k] != 0 & id_rs_used[k] & id_valid.
- Hazard stall, FWD_EN=1: any k with Match(S_EX, k) & S_EX.ld.
- Hazard stall, FWD_EN=0: any k with Match(S_EX, k) or Match(S_MEM, k).
- Control priority, combinational, evaluated every cycle:
  1. reset: all enables and flushes 0.
  2. mem_busy: all enables 0, all flushes 0; redirect and stall are deferred. EX holds ex_redirect asserted while frozen.
  3. ex_redirect: all enables 1, ifid_flush=1, idex_flush=1; any concurrent hazard stall is discarded and not counted.
  4. hazard stall: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
  5. otherwise: all enables 1, flushes 0.
- id_byp[k] = Match(S_WB, k), independent of the priority logic. With all slots invalid, every output derived from a slot is 0.
- Slot update on posedge clk:
  - if idex_en: S_EX <= (idex_flush | !id_valid) ? invalid : {1, id_rd, id_regwrite, id_is_load}.
  - if exmem_en: S_MEM <= S_EX.
  - if memwb_en: S_WB <= S_MEM.
  - A disabled slot holds its value.
- fwd_sel[k] update, when idex_en is 1:
  - flush or FWD_EN=0: 00.
  - else 01 if Match(S_EX, k) & !S_EX.ld.
  - else 10 if Match(S_MEM, k).
  - else 00.
  - EX-stage match takes precedence over MEM (youngest producer wins). Holds when idex_en=0.
- Load in S_EX never gets 01: the stall covers it. The next cycle the load sits in S_MEM and the consumer gets 10.
- stall_cnt increments by 1 in each non-reset cycle where priority level 4 is taken. It saturates at all-ones and clears only on reset.
- Reset (asynchronous, any time, including mid-stall or mid-freeze): all slots invalid, fwd_sel=0, stall_cnt=0. Enables and flushes are forced to 0 while reset is high. The first cycle after release is a normal cycle (level 5).

Test Plan:
- ALU chain: `add x5` followed by `sub x6,x5,x1` (rs[0]=5, used). Required: no stall; second instruction's EX cycle has fwd_sel[1:0]=01. With a one-instruction gap: 10. With a two-instruction gap: id_byp[0]=1 in ID, fwd_sel=00.
- Load-use: `lw x7` followed by a consumer of x7. Required: exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; then fwd_sel=10; stall_cnt=1.
- x0 and unused ports: producer rd=0 with consumer rs=0, and a producer matching only a port with id_rs_used=0. Required: no stall, fwd_sel=00, id_byp=0.
- Redirect vs stall: ex_redirect=1 in the same cycle as a load-use match. Required: ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged. With mem_busy=1 for 3 cycles before that: all enables 0 for those 3 cycles, the redirect is applied on the 4th, and scoreboard contents are unchanged across the freeze.
- FWD_EN=0 build: ALU producer followed immediately by a consumer. Required: 2 stall cycles, fwd_sel always 00, stall_cnt=2. With CNT_W=3, 9 stalls leave stall_cnt=7 (saturated).
- Asynchronous reset asserted mid-stall (between clock edges). Required: outputs immediately show enables=0, fwd_sel=0, stall_cnt=0. After release with no instructions in flight, normal operation resumes with pc_en=1.
